// File: rtl/fpu_pkg.sv
// fpu_pkg: shared floating-point defaults and operand classification type
package fpu_pkg;
  localparam int DEF_EXP_W = 8;
  localparam int DEF_FRAC_W = 23;
  localparam int GRS_W = 3;
  typedef struct packed {
    logic is_inf;
    logic is_nan;
    logic is_zero;
    logic is_denorm;
  } fp_class_t;
endpackage

// File: rtl/fadd_align_pipe_if.sv
// fadd_align_pipe_if: flush, operand input handshake and aligned-result output handshake
// Ports: slave = pipeline side, master = producer/consumer side
interface fadd_align_pipe_if import fpu_pkg::*; #(
  parameter int EXP_W = DEF_EXP_W,
  parameter int FRAC_W = DEF_FRAC_W
);
  localparam int M = FRAC_W + 1;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [EXP_W+FRAC_W:0] a;
  logic [EXP_W+FRAC_W:0] b;
  logic sub;
  logic out_valid;
  logic out_ready;
  logic [M+GRS_W-1:0] small_frac;
  logic [M-1:0] large_frac;
  logic [FRAC_W-1:0] inf_nan_frac;
  logic [EXP_W-1:0] temp_exp;
  logic s_is_nan;
  logic s_is_inf;
  logic sign;
  logic op_sub;
  modport slave (
    input flush, in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, small_frac, large_frac, inf_nan_frac, temp_exp,
    output s_is_nan, s_is_inf, sign, op_sub
  );
  modport master (
    output flush, in_valid, a, b, sub, out_ready,
    input in_ready, out_valid, small_frac, large_frac, inf_nan_frac, temp_exp,
    input s_is_nan, s_is_inf, sign, op_sub
  );
endinterface

// File: rtl/fp_classify.sv
// fp_classify: combinational inf/nan/zero/denormal classification of an operand magnitude
// Ports: mag_i = {exp, frac}; cls_o = classification flags
module fp_classify import fpu_pkg::*; #(
  parameter int EXP_W = DEF_EXP_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input logic [EXP_W+FRAC_W-1:0] mag_i,
  output fp_class_t cls_o
);
  logic e_max, e_zero, f_zero;
  assign e_max = &mag_i[EXP_W+FRAC_W-1:FRAC_W];
  assign e_zero = ~|mag_i[EXP_W+FRAC_W-1:FRAC_W];
  assign f_zero = ~|mag_i[FRAC_W-1:0];
  assign cls_o = '{
    is_inf: e_max & f_zero,
    is_nan: e_max & ~f_zero,
    is_zero: e_zero & f_zero,
    is_denorm: e_zero & ~f_zero
  };
endmodule

// File: rtl/fadd_align_pipe.sv
// fadd_align_pipe: two-stage FP add/sub front end (swap + classify, then mantissa alignment)
// Ports: clk, rst (sync, active-high); bus (slave) = flush, operand handshake, aligned result handshake
module fadd_align_pipe import fpu_pkg::*; #(
  parameter int EXP_W = DEF_EXP_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input logic clk,
  input logic rst,
  fadd_align_pipe_if.slave bus
);
  localparam int M = FRAC_W + 1;
  localparam int W = 1 + EXP_W + FRAC_W;
  fp_class_t ca, cb;
  logic v1_q, v1_d, v2_q, v2_d, adv1, adv2, exch;
  logic [W-2:0] l_d, s_d, l_q, s_q;
  logic ha, hb, hl_d, hs_d, hl_q, hs_q;
  logic sign_d, sign_q, op_sub_d, op_sub_q, nan_d, nan_q, inf_d, inf_q;
  logic [FRAC_W-2:0] fa, fb;
  logic [FRAC_W-1:0] nf_d, nf_q, nf2_q;
  logic [EXP_W-1:0] exp_l, exp_s, shift, exp2_q;
  logic [M-1:0] m_l, m_s, large_q;
  logic [2*M+1:0] ext;
  logic [M+GRS_W-1:0] small_d, small_q;
  logic nan2_q, inf2_q, sign2_q, op_sub2_q;
  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_a (.mag_i(bus.a[W-2:0]), .cls_o(ca));
  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_b (.mag_i(bus.b[W-2:0]), .cls_o(cb));
  assign adv2 = !v2_q || bus.out_ready;
  assign adv1 = !v1_q || adv2;
  assign bus.in_ready = adv1;
  assign v1_d = adv1 ? bus.in_valid : v1_q;
  assign v2_d = adv2 ? v1_q : v2_q;
  assign exch = bus.b[W-2:0] > bus.a[W-2:0];
  assign l_d = exch ? bus.b[W-2:0] : bus.a[W-2:0];
  assign s_d = exch ? bus.a[W-2:0] : bus.b[W-2:0];
  assign ha = ~(ca.is_zero | ca.is_denorm);
  assign hb = ~(cb.is_zero | cb.is_denorm);
  assign hl_d = exch ? hb : ha;
  assign hs_d = exch ? ha : hb;
  assign op_sub_d = bus.sub ^ bus.a[W-1] ^ bus.b[W-1];
  assign sign_d = exch ? bus.sub ^ bus.b[W-1] : bus.a[W-1];
  assign inf_d = ca.is_inf | cb.is_inf;
  assign nan_d = ca.is_nan | cb.is_nan | (ca.is_inf & cb.is_inf & op_sub_d);
  assign fa = bus.a[FRAC_W-2:0];
  assign fb = bus.b[FRAC_W-2:0];
  assign nf_d = nan_d ? {1'b1, fa > fb ? fa : fb} : '0;
  assign exp_l = l_q[W-2:FRAC_W];
  assign exp_s = s_q[W-2:FRAC_W];
  assign m_l = {hl_q, l_q[FRAC_W-1:0]};
  assign m_s = {hs_q, s_q[FRAC_W-1:0]};
  // a denormal sits at effective exponent 1, so a normal/denormal pair shifts one less
  assign shift = exp_l - exp_s - EXP_W'(hl_q & ~hs_q);
  assign ext = {m_s, {(M+2){1'b0}}} >> shift;
  assign small_d = int'(shift) >= M + 2 ? {{(M+2){1'b0}}, |m_s} : {ext[2*M+1:M], |ext[M-1:0]};
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end
  always_ff @(posedge clk) begin
    if (adv1 && bus.in_valid) begin
      l_q <= l_d;
      s_q <= s_d;
      hl_q <= hl_d;
      hs_q <= hs_d;
      sign_q <= sign_d;
      op_sub_q <= op_sub_d;
      nan_q <= nan_d;
      inf_q <= inf_d;
      nf_q <= nf_d;
    end
    if (adv2 && v1_q) begin
      small_q <= small_d;
      large_q <= m_l;
      exp2_q <= exp_l;
      nf2_q <= nf_q;
      nan2_q <= nan_q;
      inf2_q <= inf_q;
      sign2_q <= sign_q;
      op_sub2_q <= op_sub_q;
    end
  end
  // data registers are unreset, so outputs are masked until a valid result is present
  assign bus.out_valid = v2_q;
  assign bus.small_frac = v2_q ? small_q : '0;
  assign bus.large_frac = v2_q ? large_q : '0;
  assign bus.temp_exp = v2_q ? exp2_q : '0;
  assign bus.inf_nan_frac = v2_q ? nf2_q : '0;
  assign bus.s_is_nan = v2_q & nan2_q;
  assign bus.s_is_inf = v2_q & inf2_q;
  assign bus.sign = v2_q & sign2_q;
  assign bus.op_sub = v2_q & op_sub2_q;
endmodule

// File: tb/tb_fadd_align_pipe.sv
// tb_fadd_align_pipe: randomized and directed checks of fadd_align_pipe against a queue-based reference model
module tb_fadd_align_pipe;
  typedef struct packed {
    logic [26:0] sf;
    logic [23:0] lf;
    logic [22:0] nf;
    logic [7:0] te;
    logic nan;
    logic inf;
    logic sign;
    logic op_sub;
  } res_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int fails = 0;
  int ndel = 0;
  logic acc;
  logic saw_stall;
  res_t q[$];
  fadd_align_pipe_if bus ();
  fadd_align_pipe dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    res_t r;
    logic x, a_inf, b_inf, a_nan, b_nan;
    logic [30:0] l, sm;
    logic [21:0] fa, fb;
    longint el, es, ml, ms, sh, q4;
    x = b[30:0] > a[30:0];
    l = x ? b[30:0] : a[30:0];
    sm = x ? a[30:0] : b[30:0];
    el = longint'(l[30:23]);
    es = longint'(sm[30:23]);
    ml = (el != 0 ? 64'h800000 : 64'h0) + longint'(l[22:0]);
    ms = (es != 0 ? 64'h800000 : 64'h0) + longint'(sm[22:0]);
    sh = el - es - ((es == 0 && el != 0) ? 1 : 0);
    q4 = ms * 4;
    if (sh >= 26) r.sf = {26'd0, ms != 0};
    else r.sf = 27'(((q4 >> sh) << 1) | ((q4 % (64'd1 << sh)) != 0 ? 64'd1 : 64'd0));
    r.lf = ml[23:0];
    r.te = l[30:23];
    a_inf = a[30:23] == 8'hFF && a[22:0] == 0;
    b_inf = b[30:23] == 8'hFF && b[22:0] == 0;
    a_nan = a[30:23] == 8'hFF && a[22:0] != 0;
    b_nan = b[30:23] == 8'hFF && b[22:0] != 0;
    r.op_sub = s ^ a[31] ^ b[31];
    r.sign = x ? s ^ b[31] : a[31];
    r.inf = a_inf | b_inf;
    r.nan = a_nan | b_nan | (a_inf & b_inf & r.op_sub);
    fa = a[21:0];
    fb = b[21:0];
    r.nf = r.nan ? {1'b1, fa > fb ? fa : fb} : 23'd0;
    return r;
  endfunction
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic ordy, input logic fl, input logic r);
    res_t e;
    bus.in_valid = v;
    bus.a = a;
    bus.b = b;
    bus.sub = s;
    bus.out_ready = ordy;
    bus.flush = fl;
    rst = r;
    #1;
    chk("in_ready", bus.in_ready, (q.size() == 2 && !ordy) ? 1'b0 : 1'b1);
    if (q.size() == 0) chk("idle_valid", bus.out_valid, 1'b0);
    if (bus.out_valid && q.size() > 0) begin
      e = q[0];
      chk("small_frac", bus.small_frac, e.sf);
      chk("large_frac", bus.large_frac, e.lf);
      chk("nf_exp_flags", {bus.inf_nan_frac, bus.temp_exp, bus.s_is_nan, bus.s_is_inf, bus.sign, bus.op_sub},
          {e.nf, e.te, e.nan, e.inf, e.sign, e.op_sub});
    end else if (!bus.out_valid) begin
      chk("zero_frac", {bus.small_frac, bus.large_frac}, 64'd0);
      chk("zero_misc", {bus.inf_nan_frac, bus.temp_exp, bus.s_is_nan, bus.s_is_inf, bus.sign, bus.op_sub}, 64'd0);
    end
    acc = v && bus.in_ready;
    if (!bus.in_ready) saw_stall = 1'b1;
    if (fl || r) q.delete();
    else begin
      if (bus.out_valid && ordy && q.size() > 0) begin
        void'(q.pop_front());
        ndel++;
      end
      if (acc) q.push_back(model(a, b, s));
    end
    @(negedge clk);
  endtask
  task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [26:0] esf,
                          input logic [23:0] elf, input logic [7:0] ete, input logic [22:0] enf, input logic [3:0] efl);
    drive(1'b1, a, b, s, 1'b1, 1'b0, 1'b0);
    chk("lat1_valid", bus.out_valid, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lat2_valid", bus.out_valid, 1'b1);
    chk("d_small", bus.small_frac, esf);
    chk("d_large", bus.large_frac, elf);
    chk("d_exp", bus.temp_exp, ete);
    chk("d_nf", bus.inf_nan_frac, enf);
    chk("d_flags", {bus.s_is_nan, bus.s_is_inf, bus.sign, bus.op_sub}, efl);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  function automatic logic [31:0] rnd_op(input logic [7:0] near);
    logic [31:0] r, f;
    logic [7:0] e;
    r = $urandom;
    f = $urandom;
    case (r[2:0])
      3'd0: e = 8'h00;
      3'd1: e = 8'hFF;
      3'd2, 3'd3, 3'd4: e = near + r[11:8] - 8'd8;
      default: e = r[23:16];
    endcase
    if (r[26:25] == 2'b00) f = 32'd0;
    return {r[31], e, f[22:0]};
  endfunction
  initial begin
    logic [31:0] ops[5];
    logic [31:0] ra, rb, rr;
    int n, d0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_zero", {bus.small_frac, bus.large_frac}, 64'd0);
    directed(32'h3F800000, 32'h3F800000, 1'b0, 27'h4000000, 24'h800000, 8'h7F, 23'h0, 4'b0000);
    directed(32'h3F800000, 32'h30800000, 1'b0, 27'h0000001, 24'h800000, 8'h7F, 23'h0, 4'b0000);
    directed(32'h00000001, 32'h00800000, 1'b0, 27'h0000008, 24'h800000, 8'h01, 23'h0, 4'b0000);
    directed(32'h7F800000, 32'h7F800000, 1'b1, 27'h4000000, 24'h800000, 8'hFF, 23'h400000, 4'b1101);
    directed(32'h7FC00001, 32'h3F800000, 1'b0, 27'h0000001, 24'hC00001, 8'hFF, 23'h400001, 4'b1000);
    for (int i = 0; i < 5; i++) ops[i] = rnd_op(8'h80);
    n = 0;
    d0 = ndel;
    saw_stall = 1'b0;
    for (int c = 0; c < 14; c++) begin
      drive(n < 5, ops[n % 5], ops[(n + 1) % 5], n[0], !(c >= 3 && c < 6), 1'b0, 1'b0);
      if (acc) n++;
    end
    chk("stream_accepted", n, 5);
    chk("stream_stall", saw_stall, 1'b1);
    chk("stream_delivered", ndel - d0, 5);
    drive(1'b1, 32'h40000000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h40400000, 32'h3F000000, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h40800000, 32'h3E800000, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    repeat (3) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h40000000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h40400000, 32'h3F000000, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    repeat (3) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 600; c++) begin
      rr = $urandom;
      ra = rnd_op(8'h80);
      rb = rr[7:6] == 2'b00 ? ra : rnd_op(ra[30:23]);
      drive(rr[1:0] != 2'b00, ra, rb, rr[2], rr[5:4] != 2'b00, rr[15:10] == 6'd0, 1'b0);
    end
    repeat (4) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
